// File: rtl/lsu_dccm_arb.sv
// rtl/lsu_dccm_arb.sv - DCCM port arbiter for loads, store-buffer drain and queued DMA
// Loads own the read port; bounded-wait counters steal a DC1 cycle for starved writers.
module lsu_dccm_arb #(
  parameter int DCCM_BITS      = 16,
  parameter int WIDTH_BITS     = 2,
  parameter int BANK_BITS      = 3,
  parameter int SB_STARVE_MAX  = 4,
  parameter int DMA_STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_req,
  input  logic [DCCM_BITS-1:0] ld_addr_lo,
  input  logic [DCCM_BITS-1:0] ld_addr_hi,
  output logic                 ld_stall,
  input  logic                 sb_req,
  input  logic [DCCM_BITS-1:0] sb_addr,
  output logic                 sb_gnt,
  input  logic                 dma_req_valid,
  input  logic                 dma_req_write,
  input  logic [DCCM_BITS-1:0] dma_req_addr,
  output logic                 dma_req_ready,
  output logic                 dma_gnt,
  output logic                 dma_rsp_valid,
  output logic                 rd_en,
  output logic                 rd_sel,
  output logic [DCCM_BITS-1:0] rd_addr_lo,
  output logic [DCCM_BITS-1:0] rd_addr_hi,
  output logic                 wr_en,
  output logic                 wr_sel,
  output logic [DCCM_BITS-1:0] wr_addr
);

  localparam int SB_W  = $clog2(SB_STARVE_MAX + 1);
  localparam int DMA_W = $clog2(DMA_STARVE_MAX + 1);

  logic                 fifo_wr   [2];
  logic [DCCM_BITS-1:0] fifo_addr [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic                 push, pop;
  logic                 head_valid, head_write;
  logic [DCCM_BITS-1:0] head_addr;

  logic [SB_W-1:0]      sb_wait, sb_wait_nxt;
  logic [DMA_W-1:0]     dma_wait, dma_wait_nxt;
  logic                 dma_starve, sb_starve_nxt, dma_starve_nxt, ld_stall_nxt;
  logic [1:0]           rsp_q;

  logic                 ld_rd, dma_rd, sb_wr, dma_wr;
  logic                 sb_ok, dma_wr_ok, dma_first;
  logic [BANK_BITS-1:0] bank_lo, bank_hi, bank_sb, bank_head;

  assign head_valid    = (count != 2'd0);
  assign head_write    = fifo_wr[rd_ptr];
  assign head_addr     = fifo_addr[rd_ptr];
  assign dma_req_ready = ~count[1];
  assign push          = dma_req_valid & dma_req_ready;
  assign pop           = dma_gnt;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]   <= dma_req_write;
      fifo_addr[wr_ptr] <= dma_req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Read port: the load pipe wins unless it is being held for a forced stall.
  assign ld_rd  = ld_req & ~ld_stall;
  assign dma_rd = ~ld_rd & head_valid & ~head_write;
  assign rd_en  = ld_rd | dma_rd;
  assign rd_sel = dma_rd;

  always_comb begin
    rd_addr_lo = '0;
    rd_addr_hi = '0;
    if (ld_rd) begin
      rd_addr_lo = ld_addr_lo;
      rd_addr_hi = ld_addr_hi;
    end else if (dma_rd) begin
      rd_addr_lo = head_addr;
      rd_addr_hi = head_addr;
    end
  end

  assign bank_lo   = rd_addr_lo[WIDTH_BITS +: BANK_BITS];
  assign bank_hi   = rd_addr_hi[WIDTH_BITS +: BANK_BITS];
  assign bank_sb   = sb_addr[WIDTH_BITS +: BANK_BITS];
  assign bank_head = head_addr[WIDTH_BITS +: BANK_BITS];

  // A write may not share a bank with an active read in the same cycle.
  assign sb_ok     = sb_req & ~(rd_en & ((bank_sb == bank_lo) | (bank_sb == bank_hi)));
  assign dma_wr_ok = head_valid & head_write &
                     ~(rd_en & ((bank_head == bank_lo) | (bank_head == bank_hi)));
  assign dma_first = ld_stall & dma_starve;
  assign sb_wr     = sb_ok & ~(dma_first & dma_wr_ok);
  assign dma_wr    = dma_wr_ok & ~sb_wr;

  assign wr_en   = sb_wr | dma_wr;
  assign wr_sel  = dma_wr;
  assign wr_addr = dma_wr ? head_addr : (sb_wr ? sb_addr : '0);
  assign sb_gnt  = sb_wr;
  assign dma_gnt = dma_rd | dma_wr;

  always_comb begin
    sb_wait_nxt = '0;
    if (sb_req & ~sb_gnt)
      sb_wait_nxt = (sb_wait == SB_W'(SB_STARVE_MAX)) ? sb_wait : sb_wait + 1'b1;
    dma_wait_nxt = '0;
    if (head_valid & ~dma_gnt)
      dma_wait_nxt = (dma_wait == DMA_W'(DMA_STARVE_MAX)) ? dma_wait : dma_wait + 1'b1;
  end

  assign dma_starve     = (dma_wait == DMA_W'(DMA_STARVE_MAX));
  assign sb_starve_nxt  = (sb_wait_nxt == SB_W'(SB_STARVE_MAX));
  assign dma_starve_nxt = (dma_wait_nxt == DMA_W'(DMA_STARVE_MAX));
  // Never stall back-to-back so the load pipe always makes progress.
  assign ld_stall_nxt   = (sb_starve_nxt | dma_starve_nxt) & ~ld_stall;
  assign dma_rsp_valid  = rsp_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_wait  <= '0;
      dma_wait <= '0;
      ld_stall <= 1'b0;
      rsp_q    <= 2'b00;
    end else begin
      sb_wait  <= sb_wait_nxt;
      dma_wait <= dma_wait_nxt;
      ld_stall <= ld_stall_nxt;
      rsp_q    <= {rsp_q[0], dma_rd};
    end
  end

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// tb/tb_lsu_dccm_arb.sv - directed self-checking bench for lsu_dccm_arb
module tb_lsu_dccm_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req;
  logic [15:0] ld_addr_lo, ld_addr_hi;
  logic        ld_stall;
  logic        sb_req;
  logic [15:0] sb_addr;
  logic        sb_gnt;
  logic        dma_req_valid, dma_req_write;
  logic [15:0] dma_req_addr;
  logic        dma_req_ready, dma_gnt, dma_rsp_valid;
  logic        rd_en, rd_sel;
  logic [15:0] rd_addr_lo, rd_addr_hi;
  logic        wr_en, wr_sel;
  logic [15:0] wr_addr;

  int n_pass = 0;
  int n_checks = 0;

  lsu_dccm_arb dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr_lo(ld_addr_lo), .ld_addr_hi(ld_addr_hi), .ld_stall(ld_stall),
    .sb_req(sb_req), .sb_addr(sb_addr), .sb_gnt(sb_gnt),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write), .dma_req_addr(dma_req_addr),
    .dma_req_ready(dma_req_ready), .dma_gnt(dma_gnt), .dma_rsp_valid(dma_rsp_valid),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    ld_req = 1'b0; ld_addr_lo = '0; ld_addr_hi = '0;
    sb_req = 1'b0; sb_addr = '0;
    dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ld_stall"}, ld_stall, 1'b0);
    check({tag, " dma_rsp_valid"}, dma_rsp_valid, 1'b0);
    check({tag, " dma_req_ready"}, dma_req_ready, 1'b1);
    check({tag, " rd_en"}, rd_en, 1'b0);
    check({tag, " wr_en"}, wr_en, 1'b0);
    check({tag, " sb_gnt"}, sb_gnt, 1'b0);
    check({tag, " dma_gnt"}, dma_gnt, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;

    // No bank conflict: load bank 4, store bank 0, both issue.
    ld_req = 1'b1; ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0010;
    sb_req = 1'b1; sb_addr = 16'h0020;
    @(negedge clk);
    check("nc rd_en", rd_en, 1'b1);
    check("nc rd_sel", rd_sel, 1'b0);
    check("nc rd_addr_lo", rd_addr_lo, 16'h0010);
    check("nc wr_en", wr_en, 1'b1);
    check("nc wr_sel", wr_sel, 1'b0);
    check("nc wr_addr", wr_addr, 16'h0020);
    check("nc sb_gnt", sb_gnt, 1'b1);
    tick();
    do_reset();

    // Store-buffer starvation: load spans banks 4-5, store targets bank 5.
    ld_req = 1'b1; ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0014;
    sb_req = 1'b1; sb_addr = 16'h0014;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("sbs sb_gnt c%0d", c), sb_gnt, (c == 4 || c == 9));
      check($sformatf("sbs ld_stall c%0d", c), ld_stall, (c == 4 || c == 9));
      check($sformatf("sbs rd_en c%0d", c), rd_en, !(c == 4 || c == 9));
      if (c == 5) check("sbs sb_wait c5", dut.sb_wait, 3'd0);
      tick();
    end
    do_reset();

    // DMA read with idle load pipe.
    dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("dr dma_gnt c%0d", c), dma_gnt, (c == 1));
      check($sformatf("dr rsp c%0d", c), dma_rsp_valid, (c == 3));
      if (c == 1) begin
        check("dr rd_en", rd_en, 1'b1);
        check("dr rd_sel", rd_sel, 1'b1);
        check("dr rd_addr_lo", rd_addr_lo, 16'h0100);
        check("dr rd_addr_hi", rd_addr_hi, 16'h0100);
      end
      tick();
      dma_req_valid = 1'b0;
    end
    do_reset();

    // FIFO full and DMA starvation under a continuous load stream.
    ld_req = 1'b1; ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0010;
    for (int c = 0; c < 11; c++) begin
      dma_req_valid = (c < 2);
      dma_req_write = 1'b0;
      dma_req_addr  = (c == 0) ? 16'h0200 : 16'h0204;
      @(negedge clk);
      check($sformatf("ff ready c%0d", c), dma_req_ready, !(c >= 2 && c <= 9));
      check($sformatf("ff ld_stall c%0d", c), ld_stall, (c == 9));
      check($sformatf("ff dma_gnt c%0d", c), dma_gnt, (c == 9));
      if (c == 9) begin
        check("ff rd_sel c9", rd_sel, 1'b1);
        check("ff rd_addr_lo c9", rd_addr_lo, 16'h0200);
      end
      tick();
    end
    do_reset();

    // Dual starvation: sb and DMA both write bank 0 while loads read bank 0.
    ld_req = 1'b1; ld_addr_lo = 16'h0000; ld_addr_hi = 16'h0020;
    for (int c = 0; c < 13; c++) begin
      dma_req_valid = (c == 0);
      dma_req_write = 1'b1;
      dma_req_addr  = 16'h0040;
      sb_req  = (c >= 5 && c <= 11);
      sb_addr = 16'h0040;
      @(negedge clk);
      check($sformatf("ds ld_stall c%0d", c), ld_stall, (c == 9 || c == 11));
      check($sformatf("ds wr_en c%0d", c), wr_en, (c == 9 || c == 11));
      check($sformatf("ds dma_gnt c%0d", c), dma_gnt, (c == 9));
      check($sformatf("ds sb_gnt c%0d", c), sb_gnt, (c == 11));
      if (c == 9 || c == 11) check($sformatf("ds wr_sel c%0d", c), wr_sel, (c == 9));
      tick();
    end
    do_reset();

    // Reset mid-operation: one FIFO entry, a read in flight, a stall pending.
    for (int c = 0; c < 4; c++) begin
      ld_req = (c != 2); ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0014;
      sb_req = 1'b1; sb_addr = 16'h0014;
      dma_req_valid = (c < 2); dma_req_write = 1'b0; dma_req_addr = 16'h0114;
      @(negedge clk);
      check($sformatf("mr dma_gnt c%0d", c), dma_gnt, (c == 2));
      check($sformatf("mr sb_gnt c%0d", c), sb_gnt, 1'b0);
      check($sformatf("mr ld_stall c%0d", c), ld_stall, 1'b0);
      if (c < 3) tick();
    end
    idle();
    rst = 1'b1;
    #1;
    check_reset_outputs("mr async");
    tick();
    rst = 1'b0;
    for (int c = 4; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("mr post rsp c%0d", c), dma_rsp_valid, 1'b0);
      check($sformatf("mr post ld_stall c%0d", c), ld_stall, 1'b0);
      check($sformatf("mr post ready c%0d", c), dma_req_ready, 1'b1);
      check($sformatf("mr post dma_gnt c%0d", c), dma_gnt, 1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
